// File: rtl/timer_pkg.sv
// Shared constants and types for the interval timer: register addresses,
// CTRL bit positions and the FSM state encoding.
package timer_pkg;

  localparam logic [1:0] ADDR_LOAD   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_VALUE  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int START    = 0;
  localparam int PERIODIC = 1;
  localparam int IRQ_EN   = 2;
  localparam int PRE_LSB  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale divider: counts 0..p while enabled and pulses tick on the cycle
// the count equals p, so a tick occurs every p+1 enabled cycles.
module timer_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [PRE_W-1:0] p,
  output logic             tick
);

  logic [PRE_W-1:0] cnt;

  // Compare against the live divider value, so a new p applies at the next compare.
  assign tick = enable && (cnt == p);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/interval_timer.sv
// Programmable down-counting interval timer with register port, one-shot or
// periodic reload, pending/W1C status and a level interrupt.
module interval_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PRE_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        rd_en,
  input  logic [1:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        irq,
  output logic        running
);

  state_t             state;
  logic [WIDTH-1:0]   load;
  logic [WIDTH-1:0]   count;
  logic               ctrl_start;
  logic               ctrl_periodic;
  logic               ctrl_irq_en;
  logic [PRE_W-1:0]   ctrl_pre;
  logic               pending;

  logic               load_wr;
  logic               ctrl_wr;
  logic               status_clr;
  logic               tick;
  logic               expire;
  logic [31:0]        rd_mux;

  assign load_wr    = wr_en && (wr_addr == ADDR_LOAD);
  assign ctrl_wr    = wr_en && (wr_addr == ADDR_CTRL);
  assign status_clr = wr_en && (wr_addr == ADDR_STATUS) && wr_data[0];

  // A CTRL write (stop or restart) takes priority over a tick in the same cycle.
  assign expire  = (state == RUN) && tick && (count == '0) && !ctrl_wr;
  assign running = (state == RUN);
  assign irq     = pending & ctrl_irq_en;

  timer_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (ctrl_wr),
    .enable (state == RUN),
    .p      (ctrl_pre),
    .tick   (tick)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rd_mux = '0;
    case (rd_addr)
      ADDR_LOAD:   rd_mux = 32'(load);
      ADDR_CTRL: begin
        rd_mux[START]              = ctrl_start;
        rd_mux[PERIODIC]           = ctrl_periodic;
        rd_mux[IRQ_EN]             = ctrl_irq_en;
        rd_mux[PRE_LSB +: PRE_W]   = ctrl_pre;
      end
      ADDR_VALUE:  rd_mux = 32'(count);
      ADDR_STATUS: rd_mux[0] = pending;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      load          <= '0;
      count         <= '0;
      ctrl_start    <= 1'b0;
      ctrl_periodic <= 1'b0;
      ctrl_irq_en   <= 1'b0;
      ctrl_pre      <= '0;
      pending       <= 1'b0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
    end else begin
      if (load_wr) load <= wr_data[WIDTH-1:0];

      if (ctrl_wr) begin
        ctrl_start    <= wr_data[START];
        ctrl_periodic <= wr_data[PERIODIC];
        ctrl_irq_en   <= wr_data[IRQ_EN];
        ctrl_pre      <= wr_data[PRE_LSB +: PRE_W];
        if (wr_data[START]) begin
          count <= load;
          state <= RUN;
        end else begin
          state <= IDLE;
        end
      end else if ((state == RUN) && tick) begin
        if (count != '0) begin
          count <= count - 1'b1;
        end else if (ctrl_periodic) begin
          count <= load;
        end else begin
          ctrl_start <= 1'b0;
          state      <= IDLE;
        end
      end

      // Expiry set beats a same-cycle W1C clear.
      if (expire)          pending <= 1'b1;
      else if (status_clr) pending <= 1'b0;

      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: a register-access vector table
// followed by hand-written multi-cycle timing sequences.
module tb_interval_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        irq;
  logic        running;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  interval_timer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .irq      (irq),
    .running  (running)
  );

  typedef struct {
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [1:0]  rd_addr;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_irq;
    logic        exp_running;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic we, input logic [1:0] wa, input logic [31:0] wd,
                              input logic re, input logic [1:0] ra, input logic ev,
                              input logic [31:0] ed, input logic ei, input logic er);
    vec_t v;
    v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.rd_en = re; v.rd_addr = ra;
    v.exp_valid = ev; v.exp_data = ed; v.exp_irq = ei; v.exp_running = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    rd_en = 1'b1; rd_addr = a;
    step();
    rd_en = 1'b0;
    check({name, " valid"}, 32'(rd_valid), 32'd1);
    check(name, rd_data, exp);
  endtask

  // Steps n edges; irq must stay low until exactly the n-th edge.
  task automatic wait_expiry(input int n, input string name);
    for (int i = 1; i <= n; i++) begin
      step();
      check($sformatf("%s cyc%0d", name, i), 32'(irq), (i == n) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;

    vecs[0]  = mk(0, 2'd0, 32'h0,        1, 2'd0, 1, 32'h0,        0, 0);
    vecs[1]  = mk(0, 2'd0, 32'h0,        1, 2'd1, 1, 32'h0,        0, 0);
    vecs[2]  = mk(0, 2'd0, 32'h0,        1, 2'd2, 1, 32'h0,        0, 0);
    vecs[3]  = mk(0, 2'd0, 32'h0,        1, 2'd3, 1, 32'h0,        0, 0);
    vecs[4]  = mk(0, 2'd0, 32'h0,        0, 2'd0, 0, 32'h0,        0, 0);
    vecs[5]  = mk(1, 2'd0, 32'hDEADBEEF, 0, 2'd0, 0, 32'h0,        0, 0);
    vecs[6]  = mk(1, 2'd0, 32'h12345678, 1, 2'd0, 1, 32'hDEADBEEF, 0, 0);
    vecs[7]  = mk(0, 2'd0, 32'h0,        1, 2'd0, 1, 32'h12345678, 0, 0);
    vecs[8]  = mk(1, 2'd2, 32'h55,       0, 2'd0, 0, 32'h12345678, 0, 0);
    vecs[9]  = mk(0, 2'd0, 32'h0,        1, 2'd2, 1, 32'h0,        0, 0);
    vecs[10] = mk(1, 2'd1, 32'h0000AB06, 0, 2'd0, 0, 32'h0,        0, 0);
    vecs[11] = mk(0, 2'd0, 32'h0,        1, 2'd1, 1, 32'h0000AB06, 0, 0);
    vecs[12] = mk(1, 2'd1, 32'h0,        0, 2'd0, 0, 32'h0000AB06, 0, 0);
    vecs[13] = mk(1, 2'd3, 32'h1,        1, 2'd3, 1, 32'h0,        0, 0);

    step(); step();
    rst_n = 1'b1;
    check("reset irq", 32'(irq), 32'd0);
    check("reset running", 32'(running), 32'd0);
    check("reset rd_valid", 32'(rd_valid), 32'd0);

    // Register access table
    for (int i = 0; i < 14; i++) begin
      wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      rd_en = vecs[i].rd_en; rd_addr = vecs[i].rd_addr;
      step();
      check($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d rd_data", i), rd_data, vecs[i].exp_data);
      check($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].exp_irq));
      check($sformatf("vec%0d running", i), 32'(running), 32'(vecs[i].exp_running));
    end
    wr_en = 1'b0; rd_en = 1'b0;

    // One-shot: LOAD=3, P=0 -> expiry 4 edges after start
    wr(2'd0, 32'd3);
    wr(2'd1, 32'h5);
    check("oneshot running at start", 32'(running), 32'd1);
    wait_expiry(4, "oneshot irq");
    check("oneshot running after expiry", 32'(running), 32'd0);
    rd(2'd3, 32'h1, "oneshot status");
    rd(2'd2, 32'h0, "oneshot value");
    rd(2'd1, 32'h4, "oneshot ctrl");
    wr(2'd3, 32'h0);
    check("w1c zero no effect", 32'(irq), 32'd1);
    wr(2'd3, 32'h1);
    check("oneshot w1c", 32'(irq), 32'd0);

    // Periodic, P=2, LOAD=1 -> expiry every 6 edges
    wr(2'd0, 32'd1);
    wr(2'd1, 32'h207);
    wait_expiry(6, "periodic first");
    wr(2'd3, 32'h1);
    check("periodic w1c", 32'(irq), 32'd0);
    wait_expiry(5, "periodic second");
    check("periodic running", 32'(running), 32'd1);
    wr(2'd1, 32'h4);
    check("periodic stop", 32'(running), 32'd0);
    wr(2'd3, 32'h1);
    check("periodic final w1c", 32'(irq), 32'd0);

    // Set/clear collision: expiry every cycle while W1C is written
    wr(2'd0, 32'd0);
    wr(2'd1, 32'h7);
    for (int i = 0; i < 8; i++) begin
      wr(2'd3, 32'h1);
      check($sformatf("collision irq %0d", i), 32'(irq), 32'd1);
      check($sformatf("collision running %0d", i), 32'(running), 32'd1);
    end
    wr(2'd1, 32'h4);
    check("collision stop irq", 32'(irq), 32'd1);
    check("collision stop running", 32'(running), 32'd0);
    wr(2'd3, 32'h1);
    check("collision w1c", 32'(irq), 32'd0);
    step();
    check("collision stays clear", 32'(irq), 32'd0);

    // Mid-run LOAD change: current period unaffected, next uses new LOAD
    wr(2'd0, 32'd10);
    wr(2'd1, 32'h7);
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("midrun cyc%0d", i), 32'(irq), 32'd0);
    end
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'd2;
    rd_en = 1'b1; rd_addr = 2'd2;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    check("midrun value at write", rd_data, 32'd5);
    check("midrun cyc6", 32'(irq), 32'd0);
    wait_expiry(5, "midrun first");
    wr(2'd3, 32'h1);
    check("midrun w1c", 32'(irq), 32'd0);
    wait_expiry(2, "midrun second");
    wr(2'd1, 32'h4);

    // Reset mid-run, with a concurrent LOAD write that must be ignored
    wr(2'd0, 32'd100);
    wr(2'd1, 32'h5);
    check("pre-reset irq", 32'(irq), 32'd1);
    for (int i = 0; i < 50; i++) step();
    rd(2'd2, 32'd50, "pre-reset value");
    rst_n = 1'b0;
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'h77;
    step();
    rst_n = 1'b1; wr_en = 1'b0;
    check("post-reset running", 32'(running), 32'd0);
    check("post-reset irq", 32'(irq), 32'd0);
    check("post-reset rd_valid", 32'(rd_valid), 32'd0);
    check("post-reset rd_data", rd_data, 32'd0);
    rd(2'd0, 32'd0, "post-reset load");
    rd(2'd2, 32'd0, "post-reset value");
    rd(2'd3, 32'd0, "post-reset status");
    rd(2'd1, 32'd0, "post-reset ctrl");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
